// File: rtl/spi_regs_pkg.sv
// spi_regs_pkg: shared constants for the SPI master register bank.
// Holds the register address map, the CTRL and STATUS bit positions,
// the FLUSH command bits and the register reset values.
package spi_regs_pkg;

  localparam int ADDR_W = 4;

  // Register address map
  localparam logic [ADDR_W-1:0] ADDR_DIV_L  = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_DIV_H  = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_DATA   = 4'd3;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 4'd4;
  localparam logic [ADDR_W-1:0] ADDR_CS     = 4'd5;
  localparam logic [ADDR_W-1:0] ADDR_IMASK  = 4'd6;
  localparam logic [ADDR_W-1:0] ADDR_TX_LVL = 4'd7;
  localparam logic [ADDR_W-1:0] ADDR_RX_LVL = 4'd8;
  localparam logic [ADDR_W-1:0] ADDR_THRESH = 4'd9;
  localparam logic [ADDR_W-1:0] ADDR_FLUSH  = 4'd10;

  // CTRL bit positions; bits 5, 4 and 1 are reserved and stored as 0
  localparam int CTRL_SPE   = 7;
  localparam int CTRL_IE    = 6;
  localparam int CTRL_CPOL  = 3;
  localparam int CTRL_CPHA  = 2;
  localparam int CTRL_LSBFE = 0;
  localparam logic [7:0] CTRL_WMASK = 8'hCD;

  // Sticky STATUS bits, indexed inside the 4-bit sticky field (STATUS[7:4])
  localparam int STK_DONE   = 0;
  localparam int STK_RX_UNF = 1;
  localparam int STK_TX_OVF = 2;
  localparam int STK_RX_OVF = 3;

  // FLUSH command bits
  localparam int FLUSH_TX = 0;
  localparam int FLUSH_RX = 1;

  // Reset values
  localparam logic [7:0] CTRL_RST   = 8'h00;
  localparam logic [3:0] IMASK_RST  = 4'h0;
  localparam logic [3:0] STICKY_RST = 4'h0;

endpackage

// File: rtl/spi_regs_fifo_if.sv
// spi_regs_fifo_if: 8-bit host register bus.
//   AD_i    register address      WR_i    write strobe
//   RD_i    read strobe           Data_i  write data
//   Data_o  read data (combinational from AD_i)
// master = host side, slave = register bank side.
interface spi_regs_fifo_if;
  logic [spi_regs_pkg::ADDR_W-1:0] AD_i;
  logic                            WR_i;
  logic                            RD_i;
  logic [7:0]                      Data_i;
  logic [7:0]                      Data_o;

  modport master (output AD_i, WR_i, RD_i, Data_i, input Data_o);
  modport slave  (input AD_i, WR_i, RD_i, Data_i, output Data_o);
endinterface

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: single-clock FIFO used for the SPI TX and RX paths.
// Ports:
//   CLK_i, RSTn_i  clock, asynchronous active-low reset
//   clr            synchronous clear (same effect as reset)
//   push, wdata    write side; a push while full is dropped unless a pop
//                  happens in the same cycle (pop first, then push)
//   pop            ignored while empty
//   flush          empties the FIFO; beats a same-cycle push or pop
//   rdata          head entry, 0 while empty
//   full, empty, level  occupancy ($clog2(DEPTH)+1 bits)
module spi_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     CLK_i,
  input  logic                     RSTn_i,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_eff, pop_eff;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == FULL_CNT);
  assign level    = count_reg;
  assign pop_eff  = pop & ~empty & ~flush & ~clr;
  assign push_eff = push & (~full | pop_eff) & ~flush & ~clr;
  assign rdata    = empty ? '0 : mem[rd_ptr_reg];

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own
  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clr || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_eff) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_eff)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is not reset; rdata masks it while empty
  always_ff @(posedge CLK_i) begin
    if (push_eff) mem[wr_ptr_reg] <= wdata;
  end

endmodule

// File: rtl/spi_regs_fifo.sv
// spi_regs_fifo: SPI master register bank with TX/RX FIFOs.
// Ports:
//   CLK_i, RSTn_i, RST_SYNC_i  clock, async active-low reset, sync clear
//   bus            host register bus (spi_regs_fifo_if.slave)
//   Divisor_o      baud divisor; SPE_o/CPOL_o/CPHA_o/LSBFE_o control bits
//   CS_o           chip-select register
//   Xfer_Req_o, Xfer_Data_o, Xfer_Ack_i   TX byte handshake to the engine
//   Rx_Valid_i, Rx_Data_i                 received byte from the engine
//   Busy_o, INTR_o                        status outputs
// Build option: define SPI_RX_THRESH_EN to add the RX threshold register
// (address 9) and its interrupt source.
module spi_regs_fifo
  import spi_regs_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter int          NUM_CS     = 8,
  parameter logic [15:0] DIV_RST    = 16'h0001
) (
  input  logic              CLK_i,
  input  logic              RSTn_i,
  input  logic              RST_SYNC_i,
  spi_regs_fifo_if.slave    bus,
  output logic [15:0]       Divisor_o,
  output logic              SPE_o,
  output logic              CPOL_o,
  output logic              CPHA_o,
  output logic              LSBFE_o,
  output logic [NUM_CS-1:0] CS_o,
  output logic              Xfer_Req_o,
  output logic [7:0]        Xfer_Data_o,
  input  logic              Xfer_Ack_i,
  input  logic              Rx_Valid_i,
  input  logic [7:0]        Rx_Data_i,
  output logic              Busy_o,
  output logic              INTR_o
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]       div_reg;
  logic [7:0]        ctrl_reg;
  logic [NUM_CS-1:0] cs_reg;
  logic [3:0]        imask_reg;
  logic [3:0]        sticky_reg;
  logic              ack_seen_reg;

  logic          tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic          rx_pop, rx_flush, rx_full, rx_empty;
  logic [LW-1:0] tx_level, rx_level;
  logic [7:0]    rx_head;
  logic          rd_data, wr_status;
  logic [3:0]    sticky_set, w1c;
  logic [7:0]    rdata;
  logic          spe, ie;

  assign spe       = ctrl_reg[CTRL_SPE];
  assign ie        = ctrl_reg[CTRL_IE];
  assign tx_push   = bus.WR_i && (bus.AD_i == ADDR_DATA);
  assign rd_data   = bus.RD_i && (bus.AD_i == ADDR_DATA);
  assign wr_status = bus.WR_i && (bus.AD_i == ADDR_STATUS);
  assign tx_flush  = bus.WR_i && (bus.AD_i == ADDR_FLUSH) && bus.Data_i[FLUSH_TX];
  assign rx_flush  = bus.WR_i && (bus.AD_i == ADDR_FLUSH) && bus.Data_i[FLUSH_RX];

  // Xfer_Req_o implies a non-empty TX FIFO, so tx_pop never underflows
  assign Xfer_Req_o = spe & ~tx_empty;
  assign tx_pop     = Xfer_Ack_i & Xfer_Req_o;
  assign rx_pop     = rd_data & ~rx_empty;

  // Set events; a W1C in the same cycle loses to the set
  assign sticky_set[STK_DONE]   = tx_pop & (tx_level == LW'(1)) & ~tx_push;
  assign sticky_set[STK_RX_UNF] = rd_data & rx_empty;
  assign sticky_set[STK_TX_OVF] = tx_push & tx_full & ~tx_pop & ~tx_flush;
  assign sticky_set[STK_RX_OVF] = Rx_Valid_i & rx_full & ~rx_pop & ~rx_flush;
  assign w1c = wr_status ? bus.Data_i[7:4] : 4'h0;

  spi_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .CLK_i (CLK_i), .RSTn_i (RSTn_i), .clr (RST_SYNC_i),
    .push (tx_push), .pop (tx_pop), .flush (tx_flush),
    .wdata (bus.Data_i), .rdata (Xfer_Data_o),
    .full (tx_full), .empty (tx_empty), .level (tx_level)
  );

  spi_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .CLK_i (CLK_i), .RSTn_i (RSTn_i), .clr (RST_SYNC_i),
    .push (Rx_Valid_i), .pop (rx_pop), .flush (rx_flush),
    .wdata (Rx_Data_i), .rdata (rx_head),
    .full (rx_full), .empty (rx_empty), .level (rx_level)
  );

  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      div_reg      <= DIV_RST;
      ctrl_reg     <= CTRL_RST;
      cs_reg       <= '0;
      imask_reg    <= IMASK_RST;
      sticky_reg   <= STICKY_RST;
      ack_seen_reg <= 1'b0;
    end else if (RST_SYNC_i) begin
      div_reg      <= DIV_RST;
      ctrl_reg     <= CTRL_RST;
      cs_reg       <= '0;
      imask_reg    <= IMASK_RST;
      sticky_reg   <= STICKY_RST;
      ack_seen_reg <= 1'b0;
    end else begin
      if (bus.WR_i) begin
        case (bus.AD_i)
          ADDR_DIV_L: div_reg[7:0]  <= bus.Data_i;
          ADDR_DIV_H: div_reg[15:8] <= bus.Data_i;
          ADDR_CTRL:  ctrl_reg      <= bus.Data_i & CTRL_WMASK;
          ADDR_CS:    cs_reg        <= bus.Data_i[NUM_CS-1:0];
          ADDR_IMASK: imask_reg     <= bus.Data_i[7:4];
          default: ;
        endcase
      end
      sticky_reg   <= (sticky_reg & ~w1c) | sticky_set;
      ack_seen_reg <= Xfer_Ack_i;
    end
  end

`ifdef SPI_RX_THRESH_EN
  logic [LW-1:0] thresh_reg;
  logic          rx_th;

  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i)                                         thresh_reg <= '0;
    else if (RST_SYNC_i)                                 thresh_reg <= '0;
    else if (bus.WR_i && (bus.AD_i == ADDR_THRESH))      thresh_reg <= bus.Data_i[LW-1:0];
  end

  assign rx_th  = (rx_level >= thresh_reg) && (thresh_reg != '0);
  assign INTR_o = ie & spe & ((|(sticky_reg & imask_reg)) | rx_th);
`else
  assign INTR_o = ie & spe & (|(sticky_reg & imask_reg));
`endif

  always_comb begin
    rdata = 8'h00;
    case (bus.AD_i)
      ADDR_DIV_L:  rdata = div_reg[7:0];
      ADDR_DIV_H:  rdata = div_reg[15:8];
      ADDR_CTRL:   rdata = ctrl_reg;
      ADDR_DATA:   rdata = rx_head;
      ADDR_STATUS: rdata = {sticky_reg, tx_full, tx_empty, rx_full, rx_empty};
      ADDR_CS:     rdata = 8'(cs_reg);
      ADDR_IMASK:  rdata = {imask_reg, 4'h0};
      ADDR_TX_LVL: rdata = 8'(tx_level);
      ADDR_RX_LVL: rdata = 8'(rx_level);
`ifdef SPI_RX_THRESH_EN
      ADDR_THRESH: rdata = 8'(thresh_reg);
`endif
      default:     rdata = 8'h00;
    endcase
  end

  assign bus.Data_o = rdata;
  assign Divisor_o  = div_reg;
  assign SPE_o      = spe;
  assign CPOL_o     = ctrl_reg[CTRL_CPOL];
  assign CPHA_o     = ctrl_reg[CTRL_CPHA];
  assign LSBFE_o    = ctrl_reg[CTRL_LSBFE];
  assign CS_o       = cs_reg;
  assign Busy_o     = Xfer_Req_o | ack_seen_reg;

endmodule

// File: doc/spi_regs_fifo.md
Name: spi_regs_fifo

Overview:
Parametrised next-generation SPI master register bank. Adds TX/RX FIFOs, a byte-level handshake to the SPI shift engine, a configurable chip-select count, and sticky write-1-to-clear interrupt status with a mask. Sits between the 8-bit host register bus and the SPI shift/clock engine.

Parameters:
FIFO_DEPTH, 4, TX and RX FIFO entries each; power of 2, range 2..128.
NUM_CS, 8, number of chip-select outputs; range 1..8.
DIV_RST, 16'h0001, reset value of the baud divisor.

Ports:
CLK_i  in  1  system clock.
RSTn_i  in  1  reset.
RST_SYNC_i  in  1  synchronous clear, same effect as reset.
AD_i  in  4  register address.
WR_i  in  1  register write strobe.
RD_i  in  1  register read strobe; pops the RX FIFO only at DATA.
Data_i  in  8  write data.
Data_o  out  8  read data, combinational from AD_i.
Divisor_o  out  16  baud divisor.
SPE_o, CPOL_o, CPHA_o, LSBFE_o  out  1 each  control bits.
CS_o  out  NUM_CS  chip-select register value.
Xfer_Req_o  out  1  TX byte available to the engine.
Xfer_Data_o  out  8  TX FIFO head.
Xfer_Ack_i  in  1  engine accepted the head byte.
Rx_Valid_i  in  1  received byte strobe.
Rx_Data_i  in  8  received byte.
Busy_o  out  1  Xfer_Req_o is high, or Xfer_Ack_i was seen within the last cycle.
INTR_o  out  1  interrupt request.

Behaviour:
- Reset is asynchronous and active-low (RSTn_i). A single clock domain, CLK_i.
- Reset or RST_SYNC_i: Divisor=DIV_RST; CTRL, CS, IMASK, STATUS and THRESH=0; both FIFOs empty. Resulting outputs: Xfer_Req_o=0, INTR_o=0, Busy_o=0, Xfer_Data_o=0x00, CS_o=0.
- Address map:
  - 0 DIV_L; 1 DIV_H.
  - 2 CTRL {SPE, IE, 0, 0, CPOL, CPHA, 0, LSBFE}.
  - 3 DATA: write pushes TX; read returns the RX head, and RD_i pops it.
  - 4 STATUS {RX_OVF, TX_OVF, RX_UNF, DONE, TX_FULL, TX_EMPTY, RX_FULL, RX_EMPTY}. Bits 7:4 are sticky and write-1-to-clear. Bits 3:0 are live and read-only.
  - 5 CS: bits NUM_CS-1:0 writable, upper bits read 0.
  - 6 IMASK: bits 7:4 writable.
  - 7 TX_LVL; 8 RX_LVL.
  - 9 THRESH (optional feature only).
  - 10 FLUSH: bit0 empties TX, bit1 empties RX; self-clearing, reads 0.
  - All other addresses read 0 and ignore writes.
- Register writes take effect on the next clock edge. Reserved CTRL bits are stored as 0.
- TX FIFO:
  - Xfer_Req_o = SPE & !tx_empty.
  - Xfer_Ack_i pops only while Xfer_Req_o=1; otherwise it is ignored.
  - A push when full is dropped and sets TX_OVF.
  - A simultaneous push and pop leaves the level unchanged; when full, the pop happens first and the push is accepted.
- DONE: set on the edge where a pop leaves TX empty with no simultaneous push.
- RX FIFO:
  - Rx_Valid_i pushes. A push when full is dropped and sets RX_OVF unless an RX pop occurs in the same cycle.
  - Reading DATA while RX is empty returns 0x00, sets RX_UNF and does not move pointers.
- Pointers wrap modulo FIFO_DEPTH. Levels are $clog2(FIFO_DEPTH)+1 bits, zero-extended to 8.
- Clearing SPE: Xfer_Req_o drops in the same cycle (combinational). FIFO contents are retained.
- FLUSH together with a same-cycle push: the flush wins.
- A W1C clear in the same cycle as a set event: the set wins.
- INTR_o = IE & SPE & |(STATUS[7:4] & IMASK[7:4]).

Optional Feature:
SPI_RX_THRESH_EN.
- With the macro: THRESH register at address 9, bits $clog2(FIFO_DEPTH):0. A live flag RX_TH = (rx_level >= THRESH) & (THRESH != 0) is ORed into INTR_o, gated by IE & SPE. No mask bit applies.
- Without the macro: address 9 reads 0 and ignores writes; RX_TH does not exist.

Decomposition:
- Package spi_regs_pkg: address localparams, STATUS/CTRL bit indices, reset constants.
- One sub-module, spi_sync_fifo (width 8, depth param, push/pop/flush, full/empty/level), instantiated for TX and RX.

Test Plan:
- Reset: read all addresses -> DIV_L=0x01, DIV_H=0x00, all others 0x00, STATUS=0x05, INTR_o=0.
- SPE=1, push 0xA5, 0x3C; ack on two cycles -> Xfer_Data_o shows A5 then 3C; DONE set after the second ack; with IMASK=0x10 and IE=1, INTR_o=1; writing 0x10 to STATUS clears it.
- FIFO_DEPTH=4, push 5 bytes with SPE=0 -> TX_LVL=4, TX_OVF=1, Xfer_Req_o=0; set SPE -> Xfer_Req_o=1 on the next cycle.
- Push 4 RX bytes, then push plus DATA read in the same cycle -> RX_LVL stays 4, RX_OVF=0; read on an empty RX FIFO -> 0x00 and RX_UNF=1.
- Write 0x1FF pattern to CS with NUM_CS=3 -> CS_o=3'b111 and reads 0x07; FLUSH=0x03 -> both levels 0.
- With SPI_RX_THRESH_EN, THRESH=2, push 2 RX bytes -> INTR_o=1; pop one -> INTR_o=0.
